conta_votos_seq: RTL and testbench

Sequential, parametrised vote counter for N_VOTERS voters.
- Opens a voting session, accepts one ballot per voter through a valid/ready handshake and rejects duplicate or out-of-range ballots.
- Closes on command or automatically when every voter has voted, then publishes the yes/no/abstain tallies, a one-hot encoding of the yes count, and majority/tie flags.
- Sits between ballot-entry logic and display/decision logic.

---
 rtl/votos_pkg.sv | 22 ++
 rtl/decod_onehot.sv | 20 ++
 rtl/conta_votos_seq.sv | 140 ++++++++++++++
 tb/tb_conta_votos_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/votos_pkg.sv
// Shared types and width helpers for the vote-counter block and its decoders.
// Pure declarations: no logic, no latency, no flow control.
package votos_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    TALLY  = 2'd2,
    RESULT = 2'd3
  } state_t;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to address n voters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decod_onehot.sv
// Count-to-one-hot decoder: bit k of o_onehot is set iff i_cnt == k.
// Purely combinational, zero latency, no flow control.
module decod_onehot
  import votos_pkg::*;
#(
  parameter  int N  = 3,
  localparam int CW = cnt_width(N)
) (
  input  logic [CW-1:0] i_cnt,
  output logic [N:0]    o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int k = 0; k <= N; k++) begin
      o_onehot[k] = (i_cnt == CW'(k));
    end
  end

endmodule

// File: rtl/conta_votos_seq.sv
// Session vote counter: one ballot per voter via valid/ready, then yes/no/abstain tallies and flags.
// Counts update one cycle after acceptance; done pulses two cycles after close/last ballot; ready only in OPEN.
module conta_votos_seq
  import votos_pkg::*;
#(
  parameter  int N_VOTERS = 3,
  localparam int CW       = cnt_width(N_VOTERS),
  localparam int IW       = id_width(N_VOTERS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_close,
  input  logic              i_vote_valid,
  input  logic [IW-1:0]     i_vote_id,
  input  logic              i_vote_yes,
  output logic              o_vote_ready,
  output logic [CW-1:0]     o_yes_count,
  output logic [CW-1:0]     o_no_count,
  output logic [CW-1:0]     o_abstain_count,
  output logic [N_VOTERS:0] o_onehot,
  output logic              o_majority,
  output logic              o_tie,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_dup_err,
  output logic              o_id_err
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_yes;
  logic [CW-1:0]         r_no;
  logic [N_VOTERS-1:0]   r_voted;
  logic                  r_majority;
  logic                  r_tie;
  logic                  r_done;
  logic                  r_dup_err;
  logic                  r_id_err;

  logic                  w_open;
  logic                  w_hs;
  logic                  w_id_ok;
  logic [N_VOTERS-1:0]   w_id_mask;
  logic                  w_dup;
  logic                  w_accept;
  logic                  w_mask_full;
  logic                  w_start_ok;
  logic [CW:0]           w_yes_x2;

  assign w_open      = (r_state == OPEN);
  assign w_hs        = i_vote_valid & w_open;
  // N_VOTERS always fits in IW+1 bits, so this compare never truncates.
  assign w_id_ok     = ({1'b0, i_vote_id} < (IW + 1)'(N_VOTERS));
  // Out-of-range ids shift the bit out entirely, so no array index can overrun.
  assign w_id_mask   = N_VOTERS'(1) << i_vote_id;
  assign w_dup       = |(r_voted & w_id_mask);
  assign w_accept    = w_hs & w_id_ok & ~w_dup;
  assign w_mask_full = &(r_voted | w_id_mask);
  assign w_start_ok  = i_start & ((r_state == IDLE) | (r_state == RESULT));
  assign w_yes_x2    = {r_yes, 1'b0};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = OPEN;
      end
      OPEN: begin
        if (i_close || (w_accept && w_mask_full)) w_state_nxt = TALLY;
      end
      TALLY: begin
        w_state_nxt = RESULT;
      end
      RESULT: begin
        if (i_start) w_state_nxt = OPEN;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_yes      <= '0;
      r_no       <= '0;
      r_voted    <= '0;
      r_majority <= 1'b0;
      r_tie      <= 1'b0;
      r_done     <= 1'b0;
      r_dup_err  <= 1'b0;
      r_id_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= (r_state == TALLY);
      r_dup_err <= w_hs & w_id_ok & w_dup;
      r_id_err  <= w_hs & ~w_id_ok;

      if (w_start_ok) begin
        r_yes      <= '0;
        r_no       <= '0;
        r_voted    <= '0;
        r_majority <= 1'b0;
        r_tie      <= 1'b0;
      end else begin
        if (w_accept) begin
          r_voted <= r_voted | w_id_mask;
          if (i_vote_yes) r_yes <= r_yes + CW'(1);
          else            r_no  <= r_no + CW'(1);
        end
        // Counts are already final here: the last ballot landed on the previous edge.
        if (r_state == TALLY) begin
          r_majority <= (w_yes_x2 > (CW + 1)'(N_VOTERS));
          r_tie      <= (r_yes == r_no);
        end
      end
    end
  end

  decod_onehot #(
    .N (N_VOTERS)
  ) u_decod_onehot (
    .i_cnt    (r_yes),
    .o_onehot (o_onehot)
  );

  assign o_vote_ready    = w_open;
  assign o_busy          = w_open | (r_state == TALLY);
  assign o_yes_count     = r_yes;
  assign o_no_count      = r_no;
  assign o_abstain_count = CW'(N_VOTERS) - r_yes - r_no;
  assign o_majority      = r_majority;
  assign o_tie           = r_tie;
  assign o_done          = r_done;
  assign o_dup_err       = r_dup_err;
  assign o_id_err        = r_id_err;

endmodule

// File: tb/tb_conta_votos_seq.sv
// Directed bench for conta_votos_seq with 3-, 4- and 5-voter instances sharing one clock.
module tb_conta_votos_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // N_VOTERS = 3 : CW = 2, IW = 2
  logic       a_rst, a_start, a_close, a_vv, a_yes;
  logic [1:0] a_id;
  logic       a_rdy, a_maj, a_tie, a_busy, a_done, a_dup, a_iderr;
  logic [1:0] a_yc, a_nc, a_ac;
  logic [3:0] a_oh;

  // N_VOTERS = 4 : CW = 3, IW = 2
  logic       b_rst, b_start, b_close, b_vv, b_yes;
  logic [1:0] b_id;
  logic       b_rdy, b_maj, b_tie, b_busy, b_done, b_dup, b_iderr;
  logic [2:0] b_yc, b_nc, b_ac;
  logic [4:0] b_oh;

  // N_VOTERS = 5 : CW = 3, IW = 3
  logic       c_rst, c_start, c_close, c_vv, c_yes;
  logic [2:0] c_id;
  logic       c_rdy, c_maj, c_tie, c_busy, c_done, c_dup, c_iderr;
  logic [2:0] c_yc, c_nc, c_ac;
  logic [5:0] c_oh;

  conta_votos_seq #(.N_VOTERS(3)) u_a (
    .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .i_close(a_close),
    .i_vote_valid(a_vv), .i_vote_id(a_id), .i_vote_yes(a_yes),
    .o_vote_ready(a_rdy), .o_yes_count(a_yc), .o_no_count(a_nc),
    .o_abstain_count(a_ac), .o_onehot(a_oh), .o_majority(a_maj), .o_tie(a_tie),
    .o_busy(a_busy), .o_done(a_done), .o_dup_err(a_dup), .o_id_err(a_iderr)
  );

  conta_votos_seq #(.N_VOTERS(4)) u_b (
    .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_close(b_close),
    .i_vote_valid(b_vv), .i_vote_id(b_id), .i_vote_yes(b_yes),
    .o_vote_ready(b_rdy), .o_yes_count(b_yc), .o_no_count(b_nc),
    .o_abstain_count(b_ac), .o_onehot(b_oh), .o_majority(b_maj), .o_tie(b_tie),
    .o_busy(b_busy), .o_done(b_done), .o_dup_err(b_dup), .o_id_err(b_iderr)
  );

  conta_votos_seq #(.N_VOTERS(5)) u_c (
    .i_clk(clk), .i_rst(c_rst), .i_start(c_start), .i_close(c_close),
    .i_vote_valid(c_vv), .i_vote_id(c_id), .i_vote_yes(c_yes),
    .o_vote_ready(c_rdy), .o_yes_count(c_yc), .o_no_count(c_nc),
    .o_abstain_count(c_ac), .o_onehot(c_oh), .o_majority(c_maj), .o_tie(c_tie),
    .o_busy(c_busy), .o_done(c_done), .o_dup_err(c_dup), .o_id_err(c_iderr)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1; a_start = 0; a_close = 0; a_vv = 0; a_yes = 0; a_id = '0;
    b_rst = 1; b_start = 0; b_close = 0; b_vv = 0; b_yes = 0; b_id = '0;
    c_rst = 1; c_start = 0; c_close = 0; c_vv = 0; c_yes = 0; c_id = '0;
    tick(); tick();

    // 1: reset state
    chk("a_rst_yes", 32'(a_yc), 0);
    chk("a_rst_no", 32'(a_nc), 0);
    chk("a_rst_abs", 32'(a_ac), 3);
    chk("a_rst_onehot", 32'(a_oh), 1);
    chk("a_rst_busy", 32'(a_busy), 0);
    chk("a_rst_ready", 32'(a_rdy), 0);
    chk("a_rst_done", 32'(a_done), 0);
    chk("a_rst_maj", 32'(a_maj), 0);
    chk("a_rst_tie", 32'(a_tie), 0);
    chk("b_rst_abs", 32'(b_ac), 4);
    chk("c_rst_abs", 32'(c_ac), 5);
    chk("c_rst_onehot", 32'(c_oh), 1);
    a_rst = 0; b_rst = 0; c_rst = 0;

    // 2: three ballots, auto-close
    a_start = 1; tick(); a_start = 0;
    chk("a2_ready", 32'(a_rdy), 1);
    chk("a2_busy", 32'(a_busy), 1);
    a_vv = 1; a_id = 2'd0; a_yes = 1; tick();
    chk("a2_yes1", 32'(a_yc), 1);
    a_id = 2'd1; a_yes = 1; tick();
    chk("a2_yes2", 32'(a_yc), 2);
    a_id = 2'd2; a_yes = 0; tick(); a_vv = 0;
    chk("a2_tally_no", 32'(a_nc), 1);
    chk("a2_tally_busy", 32'(a_busy), 1);
    chk("a2_tally_ready", 32'(a_rdy), 0);
    chk("a2_tally_done", 32'(a_done), 0);
    tick();
    chk("a2_done", 32'(a_done), 1);
    chk("a2_yes", 32'(a_yc), 2);
    chk("a2_no", 32'(a_nc), 1);
    chk("a2_abs", 32'(a_ac), 0);
    chk("a2_onehot", 32'(a_oh), 4);
    chk("a2_maj", 32'(a_maj), 1);
    chk("a2_tie", 32'(a_tie), 0);
    chk("a2_busy_res", 32'(a_busy), 0);
    tick();
    chk("a2_done_pulse", 32'(a_done), 0);
    chk("a2_maj_hold", 32'(a_maj), 1);

    // 3: duplicate ballot then manual close
    a_start = 1; tick(); a_start = 0;
    chk("a3_cleared_yes", 32'(a_yc), 0);
    chk("a3_cleared_maj", 32'(a_maj), 0);
    chk("a3_cleared_onehot", 32'(a_oh), 1);
    chk("a3_ready", 32'(a_rdy), 1);
    a_vv = 1; a_id = 2'd1; a_yes = 1; tick();
    chk("a3_yes1", 32'(a_yc), 1);
    chk("a3_nodup", 32'(a_dup), 0);
    tick(); a_vv = 0;
    chk("a3_dup", 32'(a_dup), 1);
    chk("a3_dup_yes", 32'(a_yc), 1);
    a_close = 1; tick(); a_close = 0;
    chk("a3_dup_pulse", 32'(a_dup), 0);
    chk("a3_tally_busy", 32'(a_busy), 1);
    tick();
    chk("a3_done", 32'(a_done), 1);
    chk("a3_yes", 32'(a_yc), 1);
    chk("a3_no", 32'(a_nc), 0);
    chk("a3_abs", 32'(a_ac), 2);
    chk("a3_onehot", 32'(a_oh), 2);
    chk("a3_maj", 32'(a_maj), 0);

    // 4: out-of-range id, then ballot together with close
    a_start = 1; tick(); a_start = 0;
    a_vv = 1; a_id = 2'd3; a_yes = 1; tick();
    chk("a4_iderr", 32'(a_iderr), 1);
    chk("a4_iderr_nodup", 32'(a_dup), 0);
    chk("a4_iderr_yes", 32'(a_yc), 0);
    chk("a4_iderr_no", 32'(a_nc), 0);
    chk("a4_still_open", 32'(a_rdy), 1);
    a_id = 2'd0; a_yes = 0; a_close = 1; tick(); a_vv = 0; a_close = 0;
    chk("a4_iderr_pulse", 32'(a_iderr), 0);
    chk("a4_no_counted", 32'(a_nc), 1);
    chk("a4_tally_ready", 32'(a_rdy), 0);
    tick();
    chk("a4_done", 32'(a_done), 1);
    chk("a4_tie", 32'(a_tie), 0);
    chk("a4_maj", 32'(a_maj), 0);
    chk("a4_abs", 32'(a_ac), 2);
    chk("a4_onehot", 32'(a_oh), 1);

    // 5: four voters, 2 yes / 2 no tie, then restart from RESULT
    b_start = 1; tick(); b_start = 0;
    b_vv = 1; b_id = 2'd0; b_yes = 1; tick();
    b_id = 2'd1; b_yes = 0; tick();
    b_id = 2'd2; b_yes = 1; tick();
    b_id = 2'd3; b_yes = 0; tick(); b_vv = 0;
    chk("b5_tally_yes", 32'(b_yc), 2);
    chk("b5_tally_no", 32'(b_nc), 2);
    chk("b5_tally_ready", 32'(b_rdy), 0);
    tick();
    chk("b5_done", 32'(b_done), 1);
    chk("b5_tie", 32'(b_tie), 1);
    chk("b5_maj", 32'(b_maj), 0);
    chk("b5_onehot", 32'(b_oh), 4);
    chk("b5_abs", 32'(b_ac), 0);
    b_start = 1; tick(); b_start = 0;
    chk("b5_restart_yes", 32'(b_yc), 0);
    chk("b5_restart_no", 32'(b_nc), 0);
    chk("b5_restart_tie", 32'(b_tie), 0);
    chk("b5_restart_abs", 32'(b_ac), 4);
    chk("b5_restart_onehot", 32'(b_oh), 1);
    chk("b5_restart_ready", 32'(b_rdy), 1);
    chk("b5_restart_busy", 32'(b_busy), 1);

    // 6: five voters; IDLE ignores ballots/close, reset mid-session
    c_vv = 1; c_id = 3'd0; c_yes = 1; c_close = 1; tick(); c_vv = 0; c_close = 0;
    chk("c6_idle_yes", 32'(c_yc), 0);
    chk("c6_idle_ready", 32'(c_rdy), 0);
    chk("c6_idle_busy", 32'(c_busy), 0);
    c_start = 1; tick(); c_start = 0;
    c_vv = 1; c_id = 3'd0; c_yes = 1; tick();
    c_id = 3'd1; c_yes = 0; tick();
    c_id = 3'd4; c_yes = 1; tick();
    c_id = 3'd7; tick(); c_vv = 0;
    chk("c6_iderr7", 32'(c_iderr), 1);
    chk("c6_yes", 32'(c_yc), 2);
    chk("c6_no", 32'(c_nc), 1);
    chk("c6_abs", 32'(c_ac), 2);
    chk("c6_onehot", 32'(c_oh), 4);
    c_rst = 1; tick(); c_rst = 0;
    chk("c6_rst_yes", 32'(c_yc), 0);
    chk("c6_rst_no", 32'(c_nc), 0);
    chk("c6_rst_abs", 32'(c_ac), 5);
    chk("c6_rst_ready", 32'(c_rdy), 0);
    chk("c6_rst_busy", 32'(c_busy), 0);
    c_start = 1; tick(); c_start = 0;
    c_vv = 1; c_id = 3'd0; c_yes = 1; tick();
    chk("c6_new_yes", 32'(c_yc), 1);
    chk("c6_new_nodup", 32'(c_dup), 0);
    c_id = 3'd4; c_yes = 1; tick(); c_vv = 0;
    chk("c6_new_yes2", 32'(c_yc), 2);
    c_start = 1; tick(); c_start = 0;
    chk("c6_start_ignored", 32'(c_yc), 2);
    chk("c6_still_open", 32'(c_rdy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
